// File: rtl/fetch_stage.sv
// fetch_stage: fetch stage of the five-stage MIPS pipeline.
// Holds the fetch PC, drives the instruction-memory address and captures the
// fetched word, its PC, the delay-slot flag and the fetch exception code into
// the F/D pipeline register.
//
// Optional feature macro: FETCH_ADEL_EN (defined = AdEL fetch-address checking).
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   PC_next       in   next fetch address from the next-PC unit
//   stall         in   hold F and D
//   Req           in   exception/interrupt taken in M, flushes F/D
//   flush_D       in   squash the word currently in F
//   jump_D        in   instruction in D is a branch or jump
//   i_inst_rdata  in   IM read data for PC_F (combinational)
//   PC_F          out  current fetch PC
//   i_inst_addr   out  IM address, equal to PC_F
//   instr_D       out  F/D instruction
//   PC_D          out  F/D PC
//   BD_D          out  D instruction sits in a delay slot
//   excCode_D     out  F-side exception code (0 none, 4 AdEL)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] HANDLER  = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_next,
  input  logic        stall,
  input  logic        Req,
  input  logic        flush_D,
  input  logic        jump_D,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] i_inst_addr,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic        BD_D,
  output logic [4:0]  excCode_D
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic fault_c;

  // Fetch-address fault: misaligned or outside the instruction memory window.
`ifdef FETCH_ADEL_EN
  assign fault_c = (PC_F[1:0] != 2'b00) || (PC_F < IM_LO) || (PC_F > IM_HI);
`else
  assign fault_c = 1'b0;
`endif

  assign i_inst_addr = PC_F;

  // Fetch PC: a taken exception must load the handler even while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_F <= RESET_PC;
    end else if (Req || !stall) begin
      PC_F <= PC_next;
    end
  end

  // F/D register; a faulting fetch keeps its PC so EPC/BadVAddr are correct.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_D   <= 32'd0;
      PC_D      <= RESET_PC;
      BD_D      <= 1'b0;
      excCode_D <= EXC_NONE;
    end else if (Req) begin
      instr_D   <= 32'd0;
      PC_D      <= HANDLER;
      BD_D      <= 1'b0;
      excCode_D <= EXC_NONE;
    end else if (stall) begin
      instr_D   <= instr_D;
      PC_D      <= PC_D;
      BD_D      <= BD_D;
      excCode_D <= excCode_D;
    end else if (flush_D) begin
      instr_D   <= 32'd0;
      PC_D      <= PC_F;
      BD_D      <= 1'b0;
      excCode_D <= EXC_NONE;
    end else begin
      instr_D   <= fault_c ? 32'd0 : i_inst_rdata;
      PC_D      <= PC_F;
      BD_D      <= jump_D;
      excCode_D <= fault_c ? EXC_ADEL : EXC_NONE;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: an abstract pipeline model compared on
// every falling edge, plus directed literal checks along the test sequence.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] HANDLER  = 32'h0000_4180;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFF;
  localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_next;
  logic        stall, Req, flush_D, jump_D;
  logic [31:0] i_inst_rdata;
  logic [31:0] PC_F, i_inst_addr, instr_D, PC_D;
  logic        BD_D;
  logic [4:0]  excCode_D;

  logic        use_force;
  logic [31:0] pc_next_force;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .PC_next(PC_next), .stall(stall), .Req(Req),
    .flush_D(flush_D), .jump_D(jump_D), .i_inst_rdata(i_inst_rdata),
    .PC_F(PC_F), .i_inst_addr(i_inst_addr), .instr_D(instr_D), .PC_D(PC_D),
    .BD_D(BD_D), .excCode_D(excCode_D)
  );

  always #5 clk = ~clk;

  // IM contents: word n (1-based from IM_LO) is 0x24nn00nn-style "addiu".
  function automatic logic [31:0] im_read(input logic [31:0] a);
    logic [31:0] n;
    if (a < IM_LO || a > IM_HI) return BAD_WORD;
    n = ((a - IM_LO) >> 2) + 32'd1;
    return 32'h2400_0000 + (n << 16) + n;
  endfunction

  function automatic bit adel(input logic [31:0] a);
`ifdef FETCH_ADEL_EN
    return (a % 4 != 0) || (a < IM_LO) || (a > IM_HI);
`else
    return 1'b0;
`endif
  endfunction

  assign i_inst_rdata = im_read(i_inst_addr);
  assign PC_next = use_force ? pc_next_force : i_inst_addr + 32'd4;

  // Reference model: the fetch PC and the F/D slot as plain variables.
  logic [31:0] m_pcf, m_instr, m_pcd, m_old_pcf;
  logic        m_bd;
  logic [4:0]  m_exc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pcf = RESET_PC; m_instr = 0; m_pcd = RESET_PC; m_bd = 0; m_exc = 0;
    end else begin
      m_old_pcf = m_pcf;
      if (Req) begin
        m_instr = 0; m_pcd = HANDLER; m_bd = 0; m_exc = 0;
        m_pcf = PC_next;
      end else if (!stall) begin
        m_pcd = m_old_pcf;
        if (flush_D) begin
          m_instr = 0; m_bd = 0; m_exc = 0;
        end else begin
          m_instr = adel(m_old_pcf) ? 32'd0 : im_read(m_old_pcf);
          m_bd    = jump_D;
          m_exc   = adel(m_old_pcf) ? 5'd4 : 5'd0;
        end
        m_pcf = PC_next;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("model_PC_F", PC_F, m_pcf);
      check("model_i_inst_addr", i_inst_addr, m_pcf);
      check("model_instr_D", instr_D, m_instr);
      check("model_PC_D", PC_D, m_pcd);
      check("model_BD_D", 32'(BD_D), 32'(m_bd));
      check("model_excCode_D", 32'(excCode_D), 32'(m_exc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 0; Req = 0; flush_D = 0; jump_D = 0;
    use_force = 0; pc_next_force = 32'd0;
    step(2);
    started = 1;
    check("rst_PC_F", PC_F, 32'h3000);
    check("rst_addr", i_inst_addr, 32'h3000);
    check("rst_instr_D", instr_D, 32'h0);
    check("rst_PC_D", PC_D, 32'h3000);
    check("rst_BD_D", 32'(BD_D), 32'd0);
    check("rst_exc", 32'(excCode_D), 32'd0);
    reset = 1'b0;

    // Sequential fetch.
    step(2);
    check("seq_PC_F", PC_F, 32'h3008);
    check("seq_instr_D", instr_D, 32'h2402_0002);
    check("seq_PC_D", PC_D, 32'h3004);
    check("seq_exc", 32'(excCode_D), 32'd0);

    // Two-cycle stall holds everything.
    stall = 1;
    step(2);
    check("stall_PC_F", PC_F, 32'h3008);
    check("stall_instr_D", instr_D, 32'h2402_0002);
    check("stall_PC_D", PC_D, 32'h3004);
    stall = 0;
    step(1);
    check("resume_PC_F", PC_F, 32'h300C);
    check("resume_instr_D", instr_D, 32'h2403_0003);
    check("resume_PC_D", PC_D, 32'h3008);
    step(1);

    // Req with stall at PC_F = 0x3010.
    check("pre_req_PC_F", PC_F, 32'h3010);
    Req = 1; stall = 1; use_force = 1; pc_next_force = HANDLER;
    step(1);
    check("req_PC_F", PC_F, 32'h4180);
    check("req_instr_D", instr_D, 32'h0);
    check("req_PC_D", PC_D, 32'h4180);
    check("req_BD_D", 32'(BD_D), 32'd0);
    Req = 0; stall = 0; pc_next_force = 32'h3020;

    // Delay slot: beq in D at 0x3020, F fetching 0x3024.
    step(1);
    use_force = 0;
    step(1);
    check("br_PC_F", PC_F, 32'h3024);
    check("br_PC_D", PC_D, 32'h3020);
    check("br_instr_D", instr_D, 32'h2409_0009);
    jump_D = 1;
    step(1);
    check("bd_PC_D", PC_D, 32'h3024);
    check("bd_BD_D", 32'(BD_D), 32'd1);
    jump_D = 0;
    step(1);
    check("bd_clear", 32'(BD_D), 32'd0);

    // Misaligned then out-of-range fetch.
    use_force = 1; pc_next_force = 32'h3002;
    step(1);
    use_force = 0;
    step(1);
    check("mis_PC_D", PC_D, 32'h3002);
`ifdef FETCH_ADEL_EN
    check("mis_exc", 32'(excCode_D), 32'd4);
    check("mis_instr_D", instr_D, 32'h0);
`else
    check("mis_exc", 32'(excCode_D), 32'd0);
    check("mis_instr_D", instr_D, 32'h2401_0001);
`endif
    use_force = 1; pc_next_force = 32'h7000;
    step(1);
    use_force = 0;
    step(1);
    check("oor_PC_D", PC_D, 32'h7000);
`ifdef FETCH_ADEL_EN
    check("oor_exc", 32'(excCode_D), 32'd4);
    check("oor_instr_D", instr_D, 32'h0);
`else
    check("oor_exc", 32'(excCode_D), 32'd0);
    check("oor_instr_D", instr_D, BAD_WORD);
`endif

    // flush_D at PC_F = 0x3040.
    use_force = 1; pc_next_force = 32'h3040;
    step(1);
    use_force = 0; flush_D = 1;
    step(1);
    check("flush_instr_D", instr_D, 32'h0);
    check("flush_PC_D", PC_D, 32'h3040);
    check("flush_BD_D", 32'(BD_D), 32'd0);
    check("flush_PC_F", PC_F, 32'h3044);
    flush_D = 0;
    step(2);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("arst_PC_F", PC_F, 32'h3000);
    check("arst_PC_D", PC_D, 32'h3000);
    check("arst_instr_D", instr_D, 32'h0);
    check("arst_BD_D", 32'(BD_D), 32'd0);
    check("arst_exc", 32'(excCode_D), 32'd0);
    step(1);
    reset = 1'b0;
    step(3);
    check("post_rst_PC_F", PC_F, 32'h300C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
